// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - screen geometry, game states and position type shared by the pong controller
package pong_pkg;

  localparam int WALL_TOP   = 8;
  localparam int WALL_BOT   = 470;
  localparam int WALL_RIGHT = 631;
  localparam int PAD_X0     = 28;
  localparam int PAD_X1     = 36;
  localparam int PAD_H      = 64;
  localparam int BALL_SZ    = 8;

  localparam logic [9:0] CENTRE_X  = 10'd320;
  localparam logic [9:0] CENTRE_Y  = 10'd236;
  localparam logic [9:0] PAD_Y_RST = 10'd208;

  // Legal top-left ranges derived from wall and sprite sizes
  localparam logic [9:0] BALL_Y_MIN = 10'(WALL_TOP);
  localparam logic [9:0] BALL_Y_MAX = 10'(WALL_BOT - BALL_SZ + 1);
  localparam logic [9:0] BALL_X_MAX = 10'(WALL_RIGHT - BALL_SZ);
  localparam logic [9:0] PAD_Y_MIN  = 10'(WALL_TOP);
  localparam logic [9:0] PAD_Y_MAX  = 10'(WALL_BOT - PAD_H + 1);
  localparam logic [9:0] PAD_FACE   = 10'(PAD_X1);
  localparam logic [9:0] PAD_HEIGHT = 10'(PAD_H);
  localparam logic [9:0] BALL_SIZE  = 10'(BALL_SZ);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  typedef struct packed {
    logic [9:0] pos_x;
    logic [9:0] pos_y;
  } pos_data;

  localparam pos_data CENTRE_POS = '{pos_x: CENTRE_X, pos_y: CENTRE_Y};

  function automatic logic signed [10:0] to_s11(input logic [9:0] v);
    return signed'({1'b0, v});
  endfunction

endpackage

// File: rtl/pong_pad_mover.sv
// rtl/pong_pad_mover.sv - paddle button decode, step and clamp to the playfield
module pong_pad_mover
  import pong_pkg::*;
#(
  parameter int PAD_STEP = 4
) (
  input  logic [9:0] pad_y_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  output logic [9:0] pad_y_o
);

  localparam logic signed [10:0] STEP_S = 11'(PAD_STEP);

  logic signed [10:0] cur_s;
  logic signed [10:0] step_s;

  always_comb begin
    cur_s  = to_s11(pad_y_i);
    step_s = cur_s;
    if (btn_up_i && !btn_down_i) begin
      step_s = cur_s - STEP_S;
    end else if (btn_down_i && !btn_up_i) begin
      step_s = cur_s + STEP_S;
    end
    if (step_s < to_s11(PAD_Y_MIN)) begin
      step_s = to_s11(PAD_Y_MIN);
    end else if (step_s > to_s11(PAD_Y_MAX)) begin
      step_s = to_s11(PAD_Y_MAX);
    end
    pad_y_o = step_s[9:0];
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - per-frame pong sequencer; BALL_SPEEDUP_EN adds a speed register raised every 4th hit
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_STEP   = 2,
  parameter int PAD_STEP    = 4,
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_y,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       miss_pulse
);

  localparam int                MC_W      = $clog2(MISS_FRAMES + 1);
  localparam logic [MC_W-1:0]   MISS_LAST = MC_W'(MISS_FRAMES - 1);
  localparam logic [2:0]        STEP_RST  = 3'(BALL_STEP);
  localparam logic [2:0]        LIVES_RST = 3'(LIVES);

  game_state_t     state_q, state_d;
  pos_data         ball_q, ball_d;
  logic            vx_neg_q, vx_neg_d;
  logic            vy_neg_q, vy_neg_d;
  logic [9:0]      pad_q, pad_d, pad_next;
  logic [7:0]      score_q, score_d, score_inc;
  logic [2:0]      lives_q, lives_d;
  logic [MC_W-1:0] miss_cnt_q, miss_cnt_d;
  logic            miss_pulse_q, miss_pulse_d;
  logic [2:0]      spd;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] speed_q, speed_d;
  assign spd = speed_q;
`else
  assign spd = STEP_RST;
`endif

  pong_pad_mover #(
    .PAD_STEP(PAD_STEP)
  ) u_pad (
    .pad_y_i   (pad_q),
    .btn_up_i  (btn_up),
    .btn_down_i(btn_down),
    .pad_y_o   (pad_next)
  );

  // Velocity is a sign bit per axis; magnitude comes from spd
  logic signed [10:0] bx_s, by_s, pad_s, mag_s, nx, ny;
  logic               y_overlap, pad_hit;

  assign bx_s      = to_s11(ball_q.pos_x);
  assign by_s      = to_s11(ball_q.pos_y);
  assign pad_s     = to_s11(pad_q);
  assign mag_s     = signed'({8'd0, spd});
  assign nx        = vx_neg_q ? (bx_s - mag_s) : (bx_s + mag_s);
  assign ny        = vy_neg_q ? (by_s - mag_s) : (by_s + mag_s);
  assign y_overlap = (by_s + to_s11(BALL_SIZE) > pad_s) && (by_s < pad_s + to_s11(PAD_HEIGHT));
  assign pad_hit   = vx_neg_q && (nx <= to_s11(PAD_FACE)) && (bx_s >= to_s11(PAD_FACE)) && y_overlap;
  assign score_inc = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    ball_d       = ball_q;
    vx_neg_d     = vx_neg_q;
    vy_neg_d     = vy_neg_q;
    pad_d        = pad_q;
    score_d      = score_q;
    lives_d      = lives_q;
    miss_cnt_d   = miss_cnt_q;
    miss_pulse_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
    speed_d      = speed_q;
`endif
    if (frame_tick) begin
      if (state_q != OVER) begin
        pad_d = pad_next;
      end
      unique case (state_q)
        SERVE: begin
          ball_d = CENTRE_POS;
          if (btn_start) begin
            state_d  = PLAY;
            vx_neg_d = 1'b1;
            vy_neg_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_d  = STEP_RST;
`endif
          end
        end
        PLAY: begin
          if (ny < to_s11(BALL_Y_MIN)) begin
            ball_d.pos_y = BALL_Y_MIN;
            vy_neg_d     = ~vy_neg_q;
          end else if (ny > to_s11(BALL_Y_MAX)) begin
            ball_d.pos_y = BALL_Y_MAX;
            vy_neg_d     = ~vy_neg_q;
          end else begin
            ball_d.pos_y = ny[9:0];
          end
          if (pad_hit) begin
            ball_d.pos_x = PAD_FACE;
            vx_neg_d     = 1'b0;
            score_d      = score_inc;
`ifdef BALL_SPEEDUP_EN
            if (score_inc[1:0] == 2'b00 && speed_q != 3'd7) begin
              speed_d = speed_q + 3'd1;
            end
`endif
          end else if (nx > to_s11(BALL_X_MAX)) begin
            ball_d.pos_x = BALL_X_MAX;
            vx_neg_d     = ~vx_neg_q;
          end else if (nx[10]) begin
            // Ball left the field past the paddle: park it at x=0
            ball_d.pos_x = '0;
            miss_pulse_d = 1'b1;
            lives_d      = lives_q - 3'd1;
            miss_cnt_d   = '0;
            state_d      = (lives_q == 3'd1) ? OVER : MISS;
          end else begin
            ball_d.pos_x = nx[9:0];
          end
        end
        MISS: begin
          miss_cnt_d = miss_cnt_q + 1'b1;
          if (miss_cnt_q == MISS_LAST) begin
            state_d  = SERVE;
            ball_d   = CENTRE_POS;
            vx_neg_d = 1'b1;
            vy_neg_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_d  = STEP_RST;
`endif
          end
        end
        OVER: begin
          if (btn_start) begin
            state_d  = SERVE;
            lives_d  = LIVES_RST;
            score_d  = '0;
            ball_d   = CENTRE_POS;
            vx_neg_d = 1'b1;
            vy_neg_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_d  = STEP_RST;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SERVE;
      ball_q       <= CENTRE_POS;
      vx_neg_q     <= 1'b1;
      vy_neg_q     <= 1'b0;
      pad_q        <= PAD_Y_RST;
      score_q      <= '0;
      lives_q      <= LIVES_RST;
      miss_cnt_q   <= '0;
      miss_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ball_q       <= ball_d;
      vx_neg_q     <= vx_neg_d;
      vy_neg_q     <= vy_neg_d;
      pad_q        <= pad_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      miss_cnt_q   <= miss_cnt_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= STEP_RST;
    end else begin
      speed_q <= speed_d;
    end
  end
`endif

  assign ball_x     = ball_q.pos_x;
  assign ball_y     = ball_q.pos_y;
  assign pad_y      = pad_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = (state_q == OVER);
  assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized scoreboard bench for pong_game_ctrl against a behavioural game model
module tb_pong_game_ctrl;

  localparam int STEP  = 2;
  localparam int PSTEP = 4;
  localparam int NLIV  = 3;
  localparam int MFR   = 60;

  localparam int S_SERVE = 0;
  localparam int S_PLAY  = 1;
  localparam int S_MISS  = 2;
  localparam int S_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_start = 1'b0;
  logic [9:0] ball_x, ball_y, pad_y;
  logic [7:0] score;
  logic [2:0] lives;
  logic       game_over, miss_pulse;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_start (btn_start),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .pad_y     (pad_y),
    .score     (score),
    .lives     (lives),
    .game_over (game_over),
    .miss_pulse(miss_pulse)
  );

  typedef struct {
    int bx, by, pad, score, lives;
    bit go, mp;
  } snap_t;

  snap_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  int m_bx, m_by, m_vx, m_vy, m_pad, m_score, m_lives, m_st, m_cnt;
  bit m_mp;
  int n_hits = 0, n_miss = 0, n_over = 0;

  function automatic snap_t model_snap();
    snap_t s;
    s.bx = m_bx; s.by = m_by; s.pad = m_pad; s.score = m_score;
    s.lives = m_lives; s.go = (m_st == S_OVER); s.mp = m_mp;
    return s;
  endfunction

  task automatic model_centre();
    m_bx = 320; m_by = 236; m_vx = -STEP; m_vy = STEP;
  endtask

  task automatic model_reset();
    model_centre();
    m_pad = 208; m_score = 0; m_lives = NLIV; m_st = S_SERVE; m_cnt = 0; m_mp = 0;
  endtask

  task automatic model_tick(input bit up, input bit dn, input bit st);
    int old_pad, nx, ny, ynew;
    bit hit;
    old_pad = m_pad;
    m_mp = 0;
    if (m_st != S_OVER) begin
      if (up && !dn) m_pad = (m_pad - PSTEP < 8) ? 8 : m_pad - PSTEP;
      else if (dn && !up) m_pad = (m_pad + PSTEP > 407) ? 407 : m_pad + PSTEP;
    end
    case (m_st)
      S_SERVE: if (st) begin m_st = S_PLAY; m_vx = -STEP; m_vy = STEP; end
      S_PLAY: begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        hit = (m_vx < 0) && (nx <= 36) && (m_bx >= 36) && (m_by + 8 > old_pad) && (m_by < old_pad + 64);
        if (ny < 8) begin ynew = 8; m_vy = -m_vy; end
        else if (ny > 463) begin ynew = 463; m_vy = -m_vy; end
        else ynew = ny;
        if (hit) begin
          m_bx = 36; m_vx = -m_vx; m_score = (m_score < 255) ? m_score + 1 : 255; n_hits++;
        end else if (nx > 623) begin
          m_bx = 623; m_vx = -m_vx;
        end else if (nx < 0) begin
          m_bx = 0; m_mp = 1; m_lives = m_lives - 1; m_cnt = 0; n_miss++;
          m_st = (m_lives == 0) ? S_OVER : S_MISS;
          if (m_lives == 0) n_over++;
        end else begin
          m_bx = nx;
        end
        m_by = ynew;
      end
      S_MISS: begin
        m_cnt++;
        if (m_cnt == MFR) begin m_st = S_SERVE; model_centre(); end
      end
      default: if (st) begin m_st = S_SERVE; m_lives = NLIV; m_score = 0; model_centre(); end
    endcase
  endtask

  // Drives one cycle of inputs and queues the expected outcome of any update it causes
  task automatic apply(input bit r, input bit tk, input bit up, input bit dn, input bit st);
    @(posedge clk);
    #1;
    rst = r; frame_tick = tk; btn_up = up; btn_down = dn; btn_start = st;
    if (r) begin
      model_reset();
      exp_q.push_back(model_snap());
    end else if (tk) begin
      model_tick(up, dn, st);
      exp_q.push_back(model_snap());
    end
  endtask

  task automatic tick_gap(input bit up, input bit dn, input bit st);
    apply(0, 1, up, dn, st);
    apply(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic check(input snap_t e, input string tag);
    n_vec++;
    if (ball_x !== 10'(e.bx) || ball_y !== 10'(e.by) || pad_y !== 10'(e.pad) ||
        score !== 8'(e.score) || lives !== 3'(e.lives) || game_over !== e.go || miss_pulse !== e.mp) begin
      n_err++;
      $display("FAIL %s t=%0t: got ball=(%0d,%0d) pad=%0d score=%0d lives=%0d over=%0b miss=%0b, expected ball=(%0d,%0d) pad=%0d score=%0d lives=%0d over=%0b miss=%0b",
               tag, $time, ball_x, ball_y, pad_y, score, lives, game_over, miss_pulse,
               e.bx, e.by, e.pad, e.score, e.lives, e.go, e.mp);
    end
  endtask

  logic  upd = 1'b0;
  bit    have_exp = 0;
  snap_t cur;

  always @(posedge clk) upd <= rst | frame_tick;

  always @(negedge clk) begin
    if (upd) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard t=%0t: got an update with no expected entry, required a queued entry", $time);
      end else begin
        cur = exp_q.pop_front();
        have_exp = 1;
        check(cur, "update");
        cur.mp = 0;
      end
    end else if (have_exp) begin
      check(cur, "hold");
    end
  end

  initial begin
    bit good, up, dn, st;
    int tgt;
    repeat (3) apply(1, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 1);
    repeat (5) tick_gap(0, 0, 0);
    tick_gap(0, 0, 1);
    repeat (3) tick_gap(0, 0, 0);
    repeat (60) tick_gap(1, 0, 0);
    repeat (10) tick_gap(1, 1, 0);
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000) apply(1, 1, 1, 0, 1);
      good = ((i / 400) % 2) == 0;
      st = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 99) < (good ? 92 : 25)) begin
        tgt = m_by + 4 - 32;
        up = (m_pad > tgt + 2);
        dn = (m_pad < tgt - 2);
      end else begin
        up = $urandom_range(0, 1);
        dn = $urandom_range(0, 1);
      end
      repeat ($urandom_range(0, 2)) apply(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      apply(0, 1, up, dn, st);
    end
    repeat (4) apply(0, 0, 0, 0, 0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected updates never seen, required 0", exp_q.size());
    end
    $display("model events: hits=%0d misses=%0d game_overs=%0d", n_hits, n_miss, n_over);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
